// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT result readout path.
package fft_pkg;

    localparam int FFT_WIDTH = 16;
    localparam int FFT_M     = 9;

    // RAM word packing: real in the upper half, imaginary in the lower half
    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FINISH
    } state_t;

    // Reverses the low n bits of x; callers size-cast the result to n bits.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned n);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) r[i] = x[n-1-i];
        end
        return r;
    endfunction

    // |re|+|im| of sign-extended components; callers size-cast to width+1.
    // Components of up to 31 bits never hit the -2**31 corner here.
    function automatic logic [32:0] cabs_l1(input logic signed [31:0] re,
                                            input logic signed [31:0] im);
        logic [31:0] a;
        logic [31:0] b;
        a = re[31] ? 32'(-re) : 32'(re);
        b = im[31] ? 32'(-im) : 32'(im);
        return 33'(a) + 33'(b);
    endfunction

endpackage

// File: rtl/fft_bin_reg.sv
// Single-entry output register for one FFT bin, with the |re|+|im| magnitude stage.
module fft_bin_reg
    import fft_pkg::*;
#(
    parameter int width = FFT_WIDTH,
    parameter int M     = FFT_M
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    ready,
    input  logic [2*width-1:0]      data,
    input  logic [M-1:0]            bin,
    input  logic                    last,
    output logic                    valid,
    output logic [M-1:0]            out_bin,
    output logic signed [width-1:0] out_re,
    output logic signed [width-1:0] out_im,
    output logic [width:0]          out_mag,
    output logic                    out_last
);

    logic signed [width-1:0] re_in;
    logic signed [width-1:0] im_in;
    logic [width:0]          mag_in;

    assign re_in  = data[2*width-1:width];
    assign im_in  = data[width-1:0];
    assign mag_in = (width+1)'(cabs_l1(32'(re_in), 32'(im_in)));

    // A load wins over a handshake: the slot is refilled in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid    <= 1'b0;
            out_bin  <= '0;
            out_re   <= '0;
            out_im   <= '0;
            out_mag  <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            out_bin  <= bin;
            out_re   <= re_in;
            out_im   <= im_in;
            out_mag  <= mag_in;
            out_last <= last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_result_reader.sv
// Streams a finished FFT frame out of the working RAM, one bin per valid/ready handshake.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int width  = FFT_WIDTH,
    parameter int M      = FFT_M,
    parameter int HALF   = 0,
    parameter int BITREV = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic [M-1:0]            rd_adr,
    input  logic [2*width-1:0]      rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [M-1:0]            out_bin,
    output logic signed [width-1:0] out_re,
    output logic signed [width-1:0] out_im,
    output logic [width:0]          out_mag,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam logic [M:0] LASTBIN = (HALF != 0) ? (M+1)'((1 << (M-1)) - 1)
                                                 : (M+1)'((1 << M) - 1);

    state_t     state;
    state_t     state_nxt;
    logic [M:0] cnt;
    logic [M-1:0] bin_idx;
    logic       hs;
    logic       load;

    assign bin_idx = cnt[M-1:0];
    assign rd_adr  = (BITREV != 0) ? M'(bitrev(32'(bin_idx), M)) : bin_idx;
    assign hs      = out_valid && out_ready;
    // cnt carries one extra bit so it can sit at LASTBIN+1 once the frame is exhausted
    assign load    = (state == ST_STREAM) && (!out_valid || hs) && (cnt <= LASTBIN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                cnt <= '0;
            end else if (load) begin
                cnt <= cnt + (M+1)'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (hs && out_last) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    fft_bin_reg #(
        .width (width),
        .M     (M)
    ) u_bin_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .ready    (out_ready),
        .data     (rd_data),
        .bin      (bin_idx),
        .last     (cnt == LASTBIN),
        .valid    (out_valid),
        .out_bin  (out_bin),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_mag  (out_mag),
        .out_last (out_last)
    );

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench: a 512-bin natural-order reader and an 8-point half-spectrum bit-reversed reader.
module tb_fft_result_reader;
    import fft_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start, out_ready;
    logic [8:0]  rd_adr;
    logic [31:0] rd_data;
    logic        out_valid, out_last, busy, done;
    logic [8:0]  out_bin;
    logic signed [15:0] out_re, out_im;
    logic [16:0] out_mag;

    logic        start3, out_ready3;
    logic [2:0]  rd_adr3;
    logic [31:0] rd_data3;
    logic        out_valid3, out_last3, busy3, done3;
    logic [2:0]  out_bin3;
    logic signed [15:0] out_re3, out_im3;
    logic [16:0] out_mag3;

    logic [31:0] ram  [512];
    logic [31:0] ram3 [8];

    assign rd_data  = ram[rd_adr];
    assign rd_data3 = ram3[rd_adr3];

    int n_checks = 0;
    int n_fail   = 0;

    fft_result_reader #(
        .width(16), .M(9), .HALF(0), .BITREV(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rd_adr(rd_adr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_re(out_re),
        .out_im(out_im), .out_mag(out_mag), .out_last(out_last), .busy(busy), .done(done)
    );

    fft_result_reader #(
        .width(16), .M(3), .HALF(1), .BITREV(1)
    ) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .rd_adr(rd_adr3), .rd_data(rd_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_bin(out_bin3), .out_re(out_re3),
        .out_im(out_im3), .out_mag(out_mag3), .out_last(out_last3), .busy(busy3), .done(done3)
    );

    // Reference magnitude from plain integer arithmetic on the stored word
    function automatic int ref_mag(input logic [31:0] w);
        int re, im;
        re = int'(signed'(w[31:16]));
        im = int'(signed'(w[15:0]));
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        return re + im;
    endfunction

    // Drives one frame on the 512-bin reader; abort_at >= 0 resets when that bin is presented.
    task automatic run_main_frame(input int ready_pct, input bit noise_start, input int abort_at);
        int idx, cyc;
        bit fin, acc;
        logic [31:0] w;
        logic [58:0] got, want;
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency busy=%b valid=%b want busy=1 valid=0", busy, out_valid);
        end
        @(negedge clk);
        idx = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 5000) begin
            if (idx == abort_at) break;
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_status bin=%0d busy=%b done=%b want busy=1 done=0", idx, busy, done);
            end
            if (ready_pct >= 100) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL no_bubble bin=%0d valid=%b want 1", idx, out_valid);
                end
            end
            if (out_valid) begin
                w    = ram[idx];
                want = {9'(idx), w[31:16], w[15:0], 17'(ref_mag(w)), idx == 511};
                got  = {out_bin, out_re, out_im, out_mag, out_last};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL bin_data bin=%0d got=%h want=%h", idx, got, want);
                end
            end
            out_ready = ($urandom_range(99) < ready_pct);
            start     = noise_start && ($urandom_range(7) == 0);
            acc       = out_valid && out_ready;
            if (acc) begin
                if (idx == 511) fin = 1'b1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (abort_at >= 0 && idx == abort_at && !fin) begin
            reset_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_bin, out_re, out_im, out_mag, out_last, busy, done, rd_adr} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_frame valid=%b bin=%0d re=%0d im=%0d mag=%0d last=%b busy=%b done=%b adr=%0d want all 0",
                         out_valid, out_bin, out_re, out_im, out_mag, out_last, busy, done, rd_adr);
            end
            reset_n = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", busy, out_valid);
            end
        end else if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout delivered=%0d want 512", idx);
        end else begin
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
            end
            out_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_single done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0; start3 = 1'b0; out_ready = 1'b0; out_ready3 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_bin, out_re, out_im, out_mag, out_last, busy, done, rd_adr} !== '0) begin
            n_fail++;
            $display("FAIL reset_main got=%h want 0",
                     {out_valid, out_bin, out_re, out_im, out_mag, out_last, busy, done, rd_adr});
        end
        n_checks++;
        if ({out_valid3, out_bin3, out_re3, out_im3, out_mag3, out_last3, busy3, done3, rd_adr3} !== '0) begin
            n_fail++;
            $display("FAIL reset_half got=%h want 0",
                     {out_valid3, out_bin3, out_re3, out_im3, out_mag3, out_last3, busy3, done3, rd_adr3});
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold busy=%b valid=%b done=%b want 0 0 0", busy, out_valid, done);
        end
    endtask

    task automatic test_full_frame;
        cplx_t c;
        for (int k = 0; k < 512; k++) begin
            c.re = 16'(k);
            c.im = 16'(-k);
            ram[k] = c;
        end
        run_main_frame(100, 1'b0, -1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_extremes;
        for (int k = 0; k < 512; k++) ram[k] = $urandom;
        ram[3]   = {16'h8000, 16'h8000};
        ram[4]   = {16'h7fff, 16'hffff};
        ram[5]   = {16'h8000, 16'h7fff};
        ram[511] = {16'h0000, 16'h8000};
        run_main_frame(100, 1'b0, -1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_half_bitrev;
        int exp_adr [4] = '{0, 4, 2, 6};
        int idx, cyc, nxt;
        bit fin, acc;
        logic [31:0] w;
        logic [51:0] got, want;
        for (int k = 0; k < 8; k++) ram3[k] = $urandom;
        ram3[4] = {16'h8000, 16'h8000};
        start3 = 1'b1;
        out_ready3 = 1'b0;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        idx = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 200) begin
            nxt = idx + (out_valid3 ? 1 : 0);
            if (nxt <= 3) begin
                n_checks++;
                if (rd_adr3 !== 3'(exp_adr[nxt])) begin
                    n_fail++;
                    $display("FAIL half_rd_adr cnt=%0d got=%0d want=%0d", nxt, rd_adr3, exp_adr[nxt]);
                end
            end
            if (out_valid3) begin
                n_checks++;
                if (idx > 3) begin
                    n_fail++;
                    $display("FAIL half_extra_bin got bin=%0d want none", out_bin3);
                end else begin
                    w    = ram3[exp_adr[idx]];
                    want = {3'(idx), w[31:16], w[15:0], 17'(ref_mag(w)), idx == 3};
                    got  = {out_bin3, out_re3, out_im3, out_mag3, out_last3};
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL half_bin_data bin=%0d got=%h want=%h", idx, got, want);
                    end
                end
            end
            out_ready3 = ($urandom_range(99) < 60);
            acc = out_valid3 && out_ready3;
            if (acc) begin
                if (idx == 3) fin = 1'b1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready3 = 1'b0;
        n_checks++;
        if (!fin || done3 !== 1'b1 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL half_done fin=%b done=%b busy=%b want 1 1 0", fin, done3, busy3);
        end
        @(negedge clk);
        n_checks++;
        if (done3 !== 1'b0) begin
            n_fail++;
            $display("FAIL half_done_single done=%b want 0", done3);
        end
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 512; k++) ram[k] = $urandom;
        run_main_frame(55, 1'b1, -1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        for (int k = 0; k < 512; k++) ram[k] = $urandom;
        run_main_frame(100, 1'b0, 100);
        run_main_frame(100, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 512; k++) ram[k] = $urandom;
        run_main_frame(80, 1'b0, -1);
        for (int k = 0; k < 512; k++) ram[k] = $urandom;
        run_main_frame(100, 1'b0, -1);
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_extremes;
        test_half_bitrev;
        test_backpressure;
        test_reset_mid_frame;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout time=%0t want completion", $time);
        $fatal(1, "simulation did not complete");
    end

endmodule
